pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32 pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves load-use hazards, taken-branch redirects, instruction-fetch misses and multi-cycle data-memory accesses. A watchdog traps hung data-memory transactions, and a counter reports total stall cycles.

Parameters:
TIMEOUT, 255, max consecutive data-memory wait cycles before error trap (1..2^16-1)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  clock
rstN  in  1  reset, asynchronous, active-low
rs1_ID  in  5  rs1 of instruction in ID
rs2_ID  in  5  rs2 of instruction in ID
useRs1_ID  in  1  ID instruction reads rs1
useRs2_ID  in  1  ID instruction reads rs2
memRead_EX  in  1  instruction in EX is a load
rd_EX  in  5  destination of instruction in EX
branchTaken_EX  in  1  EX resolved taken branch/jump (redirect)
imemValid  in  1  instruction memory returns valid word this cycle
dmemReq_MEM  in  1  instruction in MEM accesses data memory
dmemAck  in  1  data memory completes access this cycle
pcWrite  out  1  PC update enable
en_IF_ID  out  1  IF/ID load enable (0 = hold)
flush_IF_ID  out  1  IF/ID loads bubble
en_ID_EX  out  1  ID/EX load enable
flush_ID_EX  out  1  ID/EX loads bubble (all control fields cleared)
en_EX_MEM  out  1  EX/MEM load enable
en_MEM_WB  out  1  MEM/WB load enable
flush_MEM_WB  out  1  MEM/WB loads bubble
timeoutErr  out  1  sticky data-memory timeout flag
stallCount  out  CNT_W  saturating count of stall cycles

Behaviour:
- Flush has priority over enable inside each pipeline register and takes effect at the next clk edge. All control outputs are combinational from state and inputs, so a stall takes effect in the same cycle it is detected.
- Default (no hazard): pcWrite=1, all en=1, all flush=0.
- FSM states: RUN, DMEM_WAIT, ERROR. 16-bit waitCnt.
- dmemWait = dmemReq_MEM & ~dmemAck.
- Priority, highest first:
  1. ERROR: pcWrite=0, all en=0, all flush=0 (pipeline frozen). Exit only via reset.
  2. dmemWait (RUN or DMEM_WAIT): pcWrite=0, en_IF_ID=en_ID_EX=en_EX_MEM=0, en_MEM_WB=1, flush_MEM_WB=1 (no repeated writeback).
  3. branchTaken_EX: pcWrite=1, flush_IF_ID=1, flush_ID_EX=1. Load-use and imem miss in the same cycle are ignored.
  4. loadUse = memRead_EX & rd_EX!=0 & ((useRs1_ID & rs1_ID==rd_EX) | (useRs2_ID & rs2_ID==rd_EX)): pcWrite=0, en_IF_ID=0, flush_ID_EX=1. Exactly one bubble per load; forwarding covers the rest.
  5. ~imemValid: pcWrite=0, flush_IF_ID=1; downstream stages advance.
- FSM transitions:
  - RUN -> DMEM_WAIT on dmemWait, waitCnt<=1.
  - DMEM_WAIT: waitCnt increments each dmemWait cycle. On dmemAck -> RUN, waitCnt<=0. On dmemWait with waitCnt==TIMEOUT -> ERROR, timeoutErr<=1.
- A req and ack in the same cycle cause no stall and no state change.
- A branchTaken_EX held during DMEM_WAIT is stable (EX/MEM frozen). It is acted on in the ack cycle, per rule 3.
- stallCount increments each cycle in which pcWrite=0 and state!=ERROR. It saturates at all-ones.
- Reset (any time, including mid-wait): state=RUN, waitCnt=0, timeoutErr=0, stallCount=0. While rstN=0: pcWrite=0, all en=0, all flush=0.

Test Plan:
- rd_EX=5, memRead_EX=1, rs2_ID=5, useRs2_ID=1 -> exactly one cycle with pcWrite=0, en_IF_ID=0, flush_ID_EX=1; stallCount 0->1.
- Same as above but rd_EX=0, or useRs2_ID=0 -> no stall; outputs at default.
- branchTaken_EX=1 together with a load-use match and imemValid=0 -> pcWrite=1, flush_IF_ID=1, flush_ID_EX=1, en_IF_ID=1.
- dmemReq_MEM=1 with ack arriving 3 cycles later -> 3 frozen cycles with flush_MEM_WB=1; state returns to RUN on the ack cycle; stallCount=3. Ack in the request cycle -> 0 stall cycles.
- TIMEOUT=4, req held with no ack -> timeoutErr=1 after the 5th wait cycle; pipeline stays frozen; assert rstN=0 -> timeoutErr=0, state RUN.
- imemValid=0 for 2 cycles -> pcWrite=0, flush_IF_ID=1, en_EX_MEM=1 each cycle; stallCount +2.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Handles load-use, branch redirect, imem miss, dmem wait, dmem watchdog and stall-cycle count.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             useRs1_ID,
    input  logic             useRs2_ID,
    input  logic             memRead_EX,
    input  logic [4:0]       rd_EX,
    input  logic             branchTaken_EX,
    input  logic             imemValid,
    input  logic             dmemReq_MEM,
    input  logic             dmemAck,
    output logic             pcWrite,
    output logic             en_IF_ID,
    output logic             flush_IF_ID,
    output logic             en_ID_EX,
    output logic             flush_ID_EX,
    output logic             en_EX_MEM,
    output logic             en_MEM_WB,
    output logic             flush_MEM_WB,
    output logic             timeoutErr,
    output logic [CNT_W-1:0] stallCount
);

    localparam int unsigned WAIT_W = 16;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        ERROR     = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic dmem_wait;
    logic load_use;

    assign dmem_wait = dmemReq_MEM & ~dmemAck;
    assign load_use  = memRead_EX & (rd_EX != 5'd0) &
                       ((useRs1_ID & (rs1_ID == rd_EX)) | (useRs2_ID & (rs2_ID == rd_EX)));

    // Controls are combinational so a hazard stalls in the cycle it is seen.
    always_comb begin
        pcWrite      = 1'b1;
        en_IF_ID     = 1'b1;
        flush_IF_ID  = 1'b0;
        en_ID_EX     = 1'b1;
        flush_ID_EX  = 1'b0;
        en_EX_MEM    = 1'b1;
        en_MEM_WB    = 1'b1;
        flush_MEM_WB = 1'b0;
        if (!rstN || state_q == ERROR) begin
            pcWrite   = 1'b0;
            en_IF_ID  = 1'b0;
            en_ID_EX  = 1'b0;
            en_EX_MEM = 1'b0;
            en_MEM_WB = 1'b0;
        end else if (dmem_wait) begin
            // Bubble into MEM/WB so the stalled access does not write back twice.
            pcWrite      = 1'b0;
            en_IF_ID     = 1'b0;
            en_ID_EX     = 1'b0;
            en_EX_MEM    = 1'b0;
            flush_MEM_WB = 1'b1;
        end else if (branchTaken_EX) begin
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (load_use) begin
            pcWrite     = 1'b0;
            en_IF_ID    = 1'b0;
            flush_ID_EX = 1'b1;
        end else if (!imemValid) begin
            pcWrite     = 1'b0;
            flush_IF_ID = 1'b1;
        end
    end

    // Next state, watchdog and stall counter.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        stall_cnt_d   = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (dmem_wait) begin
                    state_d    = DMEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            DMEM_WAIT: begin
                if (dmem_wait) begin
                    if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
                        state_d       = ERROR;
                        timeout_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
        if (!pcWrite && state_q != ERROR && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign timeoutErr = timeout_err_q;
    assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; control vector is
// {pcWrite,en_IF_ID,flush_IF_ID,en_ID_EX,flush_ID_EX,en_EX_MEM,en_MEM_WB,flush_MEM_WB}.
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] C_DEF  = 8'b1101_0110;
    localparam logic [7:0] C_DMEM = 8'b0000_0011;
    localparam logic [7:0] C_BR   = 8'b1111_1110;
    localparam logic [7:0] C_LU   = 8'b0001_1110;
    localparam logic [7:0] C_IMEM = 8'b0111_0110;
    localparam logic [7:0] C_OFF  = 8'b0000_0000;

    logic clk = 1'b0;
    logic rstN;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic useRs1_ID, useRs2_ID, memRead_EX, branchTaken_EX, imemValid, dmemReq_MEM, dmemAck;
    logic pcWrite, en_IF_ID, flush_IF_ID, en_ID_EX, flush_ID_EX, en_EX_MEM, en_MEM_WB, flush_MEM_WB;
    logic timeoutErr;
    logic [31:0] stallCount;
    logic s_pc, s_eif, s_fif, s_eid, s_fid, s_eex, s_emw, s_fmw, s_to;
    logic [1:0] s_cnt;
    logic [7:0] ctl;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ctl = {pcWrite, en_IF_ID, flush_IF_ID, en_ID_EX, flush_ID_EX, en_EX_MEM, en_MEM_WB, flush_MEM_WB};

    pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rstN(rstN), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .useRs1_ID(useRs1_ID), .useRs2_ID(useRs2_ID), .memRead_EX(memRead_EX), .rd_EX(rd_EX),
        .branchTaken_EX(branchTaken_EX), .imemValid(imemValid), .dmemReq_MEM(dmemReq_MEM),
        .dmemAck(dmemAck), .pcWrite(pcWrite), .en_IF_ID(en_IF_ID), .flush_IF_ID(flush_IF_ID),
        .en_ID_EX(en_ID_EX), .flush_ID_EX(flush_ID_EX), .en_EX_MEM(en_EX_MEM),
        .en_MEM_WB(en_MEM_WB), .flush_MEM_WB(flush_MEM_WB), .timeoutErr(timeoutErr),
        .stallCount(stallCount)
    );

    // Narrow counter copy to observe saturation.
    pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rstN(rstN), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .useRs1_ID(useRs1_ID), .useRs2_ID(useRs2_ID), .memRead_EX(memRead_EX), .rd_EX(rd_EX),
        .branchTaken_EX(branchTaken_EX), .imemValid(imemValid), .dmemReq_MEM(dmemReq_MEM),
        .dmemAck(dmemAck), .pcWrite(s_pc), .en_IF_ID(s_eif), .flush_IF_ID(s_fif),
        .en_ID_EX(s_eid), .flush_ID_EX(s_fid), .en_EX_MEM(s_eex),
        .en_MEM_WB(s_emw), .flush_MEM_WB(s_fmw), .timeoutErr(s_to),
        .stallCount(s_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
        useRs1_ID = 1'b0; useRs2_ID = 1'b0; memRead_EX = 1'b0;
        branchTaken_EX = 1'b0; imemValid = 1'b1; dmemReq_MEM = 1'b0; dmemAck = 1'b0;
    endtask

    initial begin
        idle();
        rstN = 1'b0;
        #12;
        check_val("reset_ctl", 32'(ctl), 32'(C_OFF));
        check_val("reset_cnt", stallCount, 32'd0);
        check_val("reset_to", 32'(timeoutErr), 32'd0);
        step();
        rstN = 1'b1;
        #1;
        check_val("idle_ctl", 32'(ctl), 32'(C_DEF));
        step();
        check_val("idle_cnt", stallCount, 32'd0);

        // Load-use on rs2: one bubble.
        memRead_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5; useRs2_ID = 1'b1;
        #1 check_val("lu_ctl", 32'(ctl), 32'(C_LU));
        step();
        idle();
        #1 check_val("lu_after_ctl", 32'(ctl), 32'(C_DEF));
        check_val("lu_cnt", stallCount, 32'd1);

        // No hazard: rd=0, then useRs2=0.
        memRead_EX = 1'b1; rd_EX = 5'd0; rs2_ID = 5'd0; useRs2_ID = 1'b1;
        #1 check_val("lu_rd0_ctl", 32'(ctl), 32'(C_DEF));
        rd_EX = 5'd5; rs2_ID = 5'd5; useRs2_ID = 1'b0;
        #1 check_val("lu_nouse_ctl", 32'(ctl), 32'(C_DEF));
        rs1_ID = 5'd5; useRs1_ID = 1'b1;
        #1 check_val("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
        step();
        idle();
        check_val("lu_rs1_cnt", stallCount, 32'd2);

        // Branch wins over load-use and imem miss.
        memRead_EX = 1'b1; rd_EX = 5'd7; rs1_ID = 5'd7; useRs1_ID = 1'b1;
        imemValid = 1'b0; branchTaken_EX = 1'b1;
        #1 check_val("br_ctl", 32'(ctl), 32'(C_BR));
        step();
        idle();
        check_val("br_cnt", stallCount, 32'd2);

        // Instruction fetch miss for two cycles.
        imemValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 check_val("imem_ctl", 32'(ctl), 32'(C_IMEM));
            step();
        end
        idle();
        check_val("imem_cnt", stallCount, 32'd4);

        // Dmem wait of 3 cycles with a branch parked in EX.
        dmemReq_MEM = 1'b1; branchTaken_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_val("dmem_ctl", 32'(ctl), 32'(C_DMEM));
            step();
        end
        dmemAck = 1'b1;
        #1 check_val("dmem_ack_ctl", 32'(ctl), 32'(C_BR));
        step();
        idle();
        check_val("dmem_cnt", stallCount, 32'd7);

        // Req with ack in the same cycle: no stall.
        dmemReq_MEM = 1'b1; dmemAck = 1'b1;
        #1 check_val("dmem_fast_ctl", 32'(ctl), 32'(C_DEF));
        step();
        idle();
        check_val("dmem_fast_cnt", stallCount, 32'd7);

        // Wait of exactly TIMEOUT cycles must not trap after the earlier wait.
        dmemReq_MEM = 1'b1;
        for (int i = 0; i < 4; i++) step();
        dmemAck = 1'b1;
        #1 check_val("dmem4_ack_ctl", 32'(ctl), 32'(C_DEF));
        step();
        idle();
        check_val("dmem4_to", 32'(timeoutErr), 32'd0);
        check_val("dmem4_cnt", stallCount, 32'd11);

        // Hung access: trap after the 5th wait cycle.
        dmemReq_MEM = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check_val("hang_ctl", 32'(ctl), 32'(C_DMEM));
            check_val("hang_to_pre", 32'(timeoutErr), 32'd0);
            step();
        end
        check_val("hang_to", 32'(timeoutErr), 32'd1);
        check_val("hang_err_ctl", 32'(ctl), 32'(C_OFF));
        dmemAck = 1'b1; branchTaken_EX = 1'b1; imemValid = 1'b0;
        step();
        step();
        check_val("err_frozen_ctl", 32'(ctl), 32'(C_OFF));
        check_val("err_cnt", stallCount, 32'd16);
        check_val("err_to_sticky", 32'(timeoutErr), 32'd1);
        check_val("sat_cnt", 32'(s_cnt), 32'd3);

        // Asynchronous reset out of ERROR.
        idle();
        #2 rstN = 1'b0;
        #1;
        check_val("rst2_to", 32'(timeoutErr), 32'd0);
        check_val("rst2_cnt", stallCount, 32'd0);
        check_val("rst2_ctl", 32'(ctl), 32'(C_OFF));
        step();
        rstN = 1'b1;
        #1 check_val("rst2_run_ctl", 32'(ctl), 32'(C_DEF));
        dmemReq_MEM = 1'b1;
        #1 check_val("rst2_dmem_ctl", 32'(ctl), 32'(C_DMEM));
        step();
        idle();
        check_val("rst2_dmem_cnt", stallCount, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
